// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control path and its datapath.
// States, opcodes, mux selects and the bundled control-strobe struct.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore strobe map: current state (plus mem_ready while fetching) to datapath controls.
module mc_ctrl_decode
    import mips_mc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: default every output before the case so no path leaves a latch behind.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, opcode latch,
// illegal-opcode pulse and retired-instruction counter around the strobe decoder.
module multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count
);

    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic       illegal_d;
    logic       retire;
    ctrl_t      ctrl;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // Only lw/sw reach here; the opcode captured in DECODE picks the access.
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q    <= state_d;
            illegal_op <= illegal_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Write/access strobes are squashed during reset so no partial writeback escapes.
    assign pc_write      = ctrl.pc_write      & ~rst;
    assign pc_write_cond = ctrl.pc_write_cond & ~rst;
    assign ir_write      = ctrl.ir_write      & ~rst;
    assign reg_write     = ctrl.reg_write     & ~rst;
    assign mem_write     = ctrl.mem_write     & ~rst;
    assign mem_read      = ctrl.mem_read      & ~rst;
    assign iord          = ctrl.iord;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: instruction-level model pushes
// per-cycle expectations, a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk, rst, mem_ready;
    logic [5:0]    opcode;
    logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic [3:0]    state;
    logic          illegal_op;
    logic [CW-1:0] instr_count;

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [15:0] ctrl;
        bit          ill;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;
    bit   ill_pend = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    // Strobe table: {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr, input bit r);
        bit pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        bit m2r = 0, rd = 0, rw = 0, asa = 0;
        logic [1:0] asb = 2'd0, aop = 2'd0, psrc = 2'd0;
        case (st)
            0:  begin mrd = 1; asb = 2'd1; irw = mr; pw = mr; end
            1:  asb = 2'd3;
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
            9:  begin asa = 1; asb = 2'd2; end
            10: rw = 1;
            11: begin pw = 1; psrc = 2'd2; end
            default: ;
        endcase
        if (r) begin pw = 0; pwc = 0; irw = 0; rw = 0; mwr = 0; mrd = 0; end
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state", int'(state), e.st);
            check("ctrl", int'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                                alu_op, pc_source}), int'(e.ctrl));
            check("illegal_op", int'(illegal_op), int'(e.ill));
            check("instr_count", int'(instr_count), e.cnt);
        end
    end

    // One clock cycle: queue what the DUT must show this cycle, drive, advance the model.
    task automatic cyc(input int st, input bit mr, input logic [5:0] op, input bit r,
                       input bit ret);
        exp_t e;
        e.st = st; e.ctrl = exp_ctrl(st, mr, r); e.ill = ill_pend; e.cnt = cnt;
        rst = r; mem_ready = mr; opcode = op;
        sb.push_back(e);
        @(posedge clk); #1;
        if (r) begin
            cnt = 0; ill_pend = 1'b0;
        end else begin
            ill_pend = (st == 1) && !legal(op);
            if (ret) cnt = (cnt + 1) % (1 << CW);
        end
    endtask

    // Opcode is only meaningful in DECODE; every other cycle carries random garbage.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
        int  path[$];
        bit  last;
        case (op)
            6'h23:   path = '{0, 1, 2, 3, 4};
            6'h2B:   path = '{0, 1, 2, 5};
            6'h00:   path = '{0, 1, 6, 7};
            6'h08:   path = '{0, 1, 9, 10};
            6'h04:   path = '{0, 1, 8};
            6'h02:   path = '{0, 1, 11};
            default: path = '{0, 1};
        endcase
        for (int i = 0; i < path.size(); i++) begin
            last = (i == path.size() - 1) && legal(op);
            if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
                repeat ((path[i] == 0) ? fst : mst) cyc(path[i], 1'b0, 6'($urandom), 1'b0, 1'b0);
                cyc(path[i], 1'b1, 6'($urandom), 1'b0, last);
            end else if (path[i] == 1) begin
                cyc(1, 1'($urandom), op, 1'b0, last);
            end else begin
                cyc(path[i], 1'($urandom), 6'($urandom), 1'b0, last);
            end
        end
    endtask

    logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
        @(posedge clk); #1;
        cyc(0, 1'b1, 6'h00, 1'b1, 1'b0);
        cyc(0, 1'b1, 6'h00, 1'b1, 1'b0);

        run_instr(6'h23, 0, 0);
        run_instr(6'h2B, 0, 0);
        run_instr(6'h00, 0, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h23, 0, 2);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h2B, 1, 1);

        // Reset lands in a stalled store: write strobe must drop, count clears.
        cyc(0, 1'b1, 6'($urandom), 1'b0, 1'b0);
        cyc(1, 1'b1, 6'h2B, 1'b0, 1'b0);
        cyc(2, 1'b1, 6'($urandom), 1'b0, 1'b0);
        cyc(5, 1'b0, 6'($urandom), 1'b0, 1'b0);
        cyc(5, 1'b0, 6'($urandom), 1'b1, 1'b0);

        // 16 retirements from zero wrap the 4-bit counter back to 0.
        for (int i = 0; i < 16; i++) run_instr(ops[i % 6], 0, 0);

        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(7)], $urandom_range(2), $urandom_range(2));

        @(negedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
